memory_arbiter: RTL and testbench

Shares the single line-wide main-memory port between the instruction cache (refill only) and the data cache (refill and dirty-line writeback). It is a three-state sequencer that latches one request, holds a fixed-latency memory access for `MEM_LATENCY` cycles, and returns a one-cycle write-enable pulse with the line to the owning cache. It sits between the fetch/memory stages and the backing memory, and its `busy` output feeds stall control.

---
 rtl/memory_arbiter_if.sv | 46 ++++
 rtl/memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_memory_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Cache-side and memory-side signals of the shared main-memory port.
// slave is the arbiter's view; master is the caches/backing-memory view.
interface memory_arbiter_if #(
  parameter int LINE_WIDTH = 128
);
  logic                  icache_request;
  logic [31:0]           icache_address;
  logic [LINE_WIDTH-1:0] to_icache_data;
  logic                  enable_write_from_memory_to_icache;

  logic                  dcache_read_request;
  logic                  dcache_write_request;
  logic [31:0]           dcache_address;
  logic [LINE_WIDTH-1:0] dcache_write_data;
  logic [LINE_WIDTH-1:0] to_dcache_data;
  logic                  enable_write_from_memory_to_dcache;
  logic                  completed_write_to_memory;

  logic                  mem_enable;
  logic                  mem_write;
  logic [31:0]           mem_address;
  logic [LINE_WIDTH-1:0] mem_write_data;
  logic [LINE_WIDTH-1:0] mem_read_data;

  logic                  busy;

  modport slave (
    input  icache_request, icache_address,
    output to_icache_data, enable_write_from_memory_to_icache,
    input  dcache_read_request, dcache_write_request, dcache_address, dcache_write_data,
    output to_dcache_data, enable_write_from_memory_to_dcache, completed_write_to_memory,
    output mem_enable, mem_write, mem_address, mem_write_data,
    input  mem_read_data,
    output busy
  );

  modport master (
    output icache_request, icache_address,
    input  to_icache_data, enable_write_from_memory_to_icache,
    output dcache_read_request, dcache_write_request, dcache_address, dcache_write_data,
    input  to_dcache_data, enable_write_from_memory_to_dcache, completed_write_to_memory,
    input  mem_enable, mem_write, mem_address, mem_write_data,
    output mem_read_data,
    input  busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one line-wide memory port between I-cache refills and D-cache refill/writeback; one-cycle strobe
// after a MEM_LATENCY-cycle access, requests are held levels; MEMORY_ARBITER_ROUND_ROBIN_EN adds I/D fairness.
module memory_arbiter #(
  parameter int LINE_WIDTH  = 128,
  parameter int MEM_LATENCY = 5
) (
  input  logic            clock,
  input  logic            reset,
  memory_arbiter_if.slave bus
);
  localparam int OFFSET = $clog2(LINE_WIDTH / 8);
  localparam int CW     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] COUNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [31:0]   ADDR_MASK  = ~((32'd1 << OFFSET) - 32'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  owner_q, owner_d;  // 1 = D-cache
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_write_q, mem_write_d;
  logic [31:0]           mem_address_q, mem_address_d;
  logic [LINE_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic [LINE_WIDTH-1:0] icache_data_q, icache_data_d;
  logic [LINE_WIDTH-1:0] dcache_data_q, dcache_data_d;
  logic                  icache_stb_q, icache_stb_d;
  logic                  dcache_stb_q, dcache_stb_d;
  logic                  write_done_q, write_done_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic                  last_owner_q, last_owner_d;
`endif

  logic dcache_pending;
  logic grant_dcache;

  always_comb begin
    dcache_pending = bus.dcache_write_request | bus.dcache_read_request;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // On I/D contention the cache not granted last time wins.
    if (dcache_pending && bus.icache_request) grant_dcache = ~last_owner_q;
    else                                      grant_dcache = dcache_pending;
`else
    grant_dcache = dcache_pending;
`endif
  end

  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    owner_d          = owner_q;
    mem_enable_d     = mem_enable_q;
    mem_write_d      = mem_write_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    icache_data_d    = icache_data_q;
    dcache_data_d    = dcache_data_q;
    icache_stb_d     = 1'b0;
    dcache_stb_d     = 1'b0;
    write_done_d     = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    last_owner_d     = last_owner_q;
`endif
    case (state_q)
      IDLE: begin
        if (dcache_pending || bus.icache_request) begin
          state_d      = ACCESS;
          count_d      = COUNT_LOAD;
          owner_d      = grant_dcache;
          mem_enable_d = 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_owner_d = grant_dcache;
`endif
          if (grant_dcache) begin
            // Writeback always precedes a refill from the same cache.
            mem_write_d      = bus.dcache_write_request;
            mem_address_d    = bus.dcache_address & ADDR_MASK;
            mem_write_data_d = bus.dcache_write_request ? bus.dcache_write_data : '0;
          end else begin
            mem_write_d      = 1'b0;
            mem_address_d    = bus.icache_address & ADDR_MASK;
            mem_write_data_d = '0;
          end
        end
      end
      ACCESS: begin
        if (count_q == '0) begin
          state_d          = RESP;
          mem_enable_d     = 1'b0;
          mem_write_d      = 1'b0;
          mem_address_d    = '0;
          mem_write_data_d = '0;
          if (mem_write_q) begin
            write_done_d = 1'b1;
          end else if (owner_q) begin
            dcache_data_d = bus.mem_read_data;
            dcache_stb_d  = 1'b1;
          end else begin
            icache_data_d = bus.mem_read_data;
            icache_stb_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q          <= IDLE;
      count_q          <= '0;
      owner_q          <= 1'b0;
      mem_enable_q     <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      icache_data_q    <= '0;
      dcache_data_q    <= '0;
      icache_stb_q     <= 1'b0;
      dcache_stb_q     <= 1'b0;
      write_done_q     <= 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_owner_q     <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      count_q          <= count_d;
      owner_q          <= owner_d;
      mem_enable_q     <= mem_enable_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      icache_data_q    <= icache_data_d;
      dcache_data_q    <= dcache_data_d;
      icache_stb_q     <= icache_stb_d;
      dcache_stb_q     <= dcache_stb_d;
      write_done_q     <= write_done_d;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last_owner_q     <= last_owner_d;
`endif
    end
  end

  assign bus.to_icache_data                     = icache_data_q;
  assign bus.enable_write_from_memory_to_icache = icache_stb_q;
  assign bus.to_dcache_data                     = dcache_data_q;
  assign bus.enable_write_from_memory_to_dcache = dcache_stb_q;
  assign bus.completed_write_to_memory          = write_done_q;
  assign bus.mem_enable                         = mem_enable_q;
  assign bus.mem_write                          = mem_write_q;
  assign bus.mem_address                        = mem_address_q;
  assign bus.mem_write_data                     = mem_write_data_q;
  assign bus.busy                               = (state_q != IDLE);
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: per-edge vector table on a MEM_LATENCY=5 instance,
// plus a hand-written back-to-back sequence on a MEM_LATENCY=1 instance.
module tb_memory_arbiter;
  localparam int LW = 128;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [LW-1:0] WDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  memory_arbiter_if #(.LINE_WIDTH(LW)) bus_a ();
  memory_arbiter_if #(.LINE_WIDTH(LW)) bus_b ();

  memory_arbiter #(.LINE_WIDTH(LW), .MEM_LATENCY(5)) dut_a (.clock(clk), .reset(rst_a), .bus(bus_a));
  memory_arbiter #(.LINE_WIDTH(LW), .MEM_LATENCY(1)) dut_b (.clock(clk), .reset(rst_b), .bus(bus_b));

  function automatic logic [LW-1:0] pat(input logic [31:0] a);
    return {4{a ^ 32'hDEAD_BEEF}};
  endfunction

  // Backing memory: the line content is a fixed function of the address.
  assign bus_a.mem_read_data = pat(bus_a.mem_address);
  assign bus_b.mem_read_data = pat(bus_b.mem_address);

  typedef struct {
    logic rst, ic, dr, dw;
    logic [31:0] ia, da;
    logic busy, en, wr;
    logic [31:0] addr;
    logic istb, dstb, wdone;
    logic [LW-1:0] icd, dcd;
  } vec_t;

  vec_t vecs[$];
  logic [LW-1:0] exp_icd, exp_dcd;
  int checks = 0;
  int errors = 0;

  task automatic add(input int n, input logic rst, ic, dr, dw, input logic [31:0] ia, da,
                     input logic busy, en, wr, input logic [31:0] addr,
                     input logic istb, dstb, wdone);
    vec_t v;
    v.rst = rst; v.ic = ic; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da;
    v.busy = busy; v.en = en; v.wr = wr; v.addr = addr;
    v.istb = istb; v.dstb = dstb; v.wdone = wdone;
    v.icd = exp_icd; v.dcd = exp_dcd;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  localparam logic [31:0] IA  = 32'h0000_1234, IAA = 32'h0000_1230;
  localparam logic [31:0] DA  = 32'h0000_5678, DAA = 32'h0000_5670;
  localparam logic [31:0] WA  = 32'h0000_ABCD, WAA = 32'h0000_ABC0;
  localparam logic [31:0] RA  = 32'h0000_200F, RAA = 32'h0000_2000;
  localparam logic [31:0] XA  = 32'h0000_9ABC, XAA = 32'h0000_9AB0;

  bit busy_b[7]  = '{1, 1, 0, 1, 1, 0, 0};
  bit en_b[7]    = '{1, 0, 0, 1, 0, 0, 0};
  bit stb_b[7]   = '{0, 1, 0, 0, 1, 0, 0};

  initial begin
    exp_icd = '0;
    exp_dcd = '0;
    // row k drives the inputs seen at edge k; expectations are for the cycle after it
    add(2, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0);
    // contention: D-cache first, then I-cache only under round robin
    add(5, 1, 1, 1, 0, IA, DA, 1, 1, 0, DAA,  0, 0, 0);
    exp_dcd = pat(DAA);
    add(1, 1, 1, 1, 0, IA, DA, 1, 0, 0, 0,    0, 1, 0);
    add(1, 1, 1, 1, 0, IA, DA, 0, 0, 0, 0,    0, 0, 0);
    add(5, 1, 1, 1, 0, IA, DA, 1, 1, 0, RR ? IAA : DAA, 0, 0, 0);
    if (RR) exp_icd = pat(IAA);
    add(1, 1, 1, 1, 0, IA, DA, 1, 0, 0, 0,    RR, !RR, 0);
    add(1, 1, 0, 0, 0, IA, DA, 0, 0, 0, 0,    0, 0, 0);
    // I-cache refill
    add(5, 1, 1, 0, 0, IA, 0,  1, 1, 0, IAA,  0, 0, 0);
    exp_icd = pat(IAA);
    add(1, 1, 1, 0, 0, IA, 0,  1, 0, 0, 0,    1, 0, 0);
    add(1, 1, 0, 0, 0, IA, 0,  0, 0, 0, 0,    0, 0, 0);
    // writeback then refill
    add(5, 1, 0, 1, 1, 0, WA,  1, 1, 1, WAA,  0, 0, 0);
    add(1, 1, 0, 1, 1, 0, WA,  1, 0, 0, 0,    0, 0, 1);
    add(1, 1, 0, 1, 0, 0, WA,  0, 0, 0, 0,    0, 0, 0);
    add(5, 1, 0, 1, 0, 0, WA,  1, 1, 0, WAA,  0, 0, 0);
    exp_dcd = pat(WAA);
    add(1, 1, 0, 1, 0, 0, WA,  1, 0, 0, 0,    0, 1, 0);
    add(1, 1, 0, 0, 0, 0, WA,  0, 0, 0, 0,    0, 0, 0);
    // reset at edge 3 of an access, request held and regranted
    add(3, 1, 1, 0, 0, RA, 0,  1, 1, 0, RAA,  0, 0, 0);
    exp_icd = '0;
    exp_dcd = '0;
    add(1, 0, 1, 0, 0, RA, 0,  0, 0, 0, 0,    0, 0, 0);
    add(5, 1, 1, 0, 0, RA, 0,  1, 1, 0, RAA,  0, 0, 0);
    exp_icd = pat(RAA);
    add(1, 1, 1, 0, 0, RA, 0,  1, 0, 0, 0,    1, 0, 0);
    add(1, 1, 0, 0, 0, RA, 0,  0, 0, 0, 0,    0, 0, 0);
    // request dropped during ACCESS still completes, no second access
    add(2, 1, 0, 1, 0, 0, XA,  1, 1, 0, XAA,  0, 0, 0);
    add(3, 1, 0, 0, 0, 0, XA,  1, 1, 0, XAA,  0, 0, 0);
    exp_dcd = pat(XAA);
    add(1, 1, 0, 0, 0, 0, XA,  1, 0, 0, 0,    0, 1, 0);
    add(3, 1, 0, 0, 0, 0, XA,  0, 0, 0, 0,    0, 0, 0);

    bus_a.dcache_write_data    = WDATA;
    bus_b.icache_request       = 1'b0;
    bus_b.icache_address       = 32'h0000_00FF;
    bus_b.dcache_read_request  = 1'b0;
    bus_b.dcache_write_request = 1'b0;
    bus_b.dcache_address       = '0;
    bus_b.dcache_write_data    = '0;
    rst_b = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a                      = vecs[i].rst;
      bus_a.icache_request       = vecs[i].ic;
      bus_a.dcache_read_request  = vecs[i].dr;
      bus_a.dcache_write_request = vecs[i].dw;
      bus_a.icache_address       = vecs[i].ia;
      bus_a.dcache_address       = vecs[i].da;
      @(posedge clk); #1;
      check("busy",        i, LW'(bus_a.busy),       LW'(vecs[i].busy));
      check("mem_enable",  i, LW'(bus_a.mem_enable), LW'(vecs[i].en));
      check("mem_write",   i, LW'(bus_a.mem_write),  LW'(vecs[i].wr));
      check("mem_address", i, LW'(bus_a.mem_address), LW'(vecs[i].addr));
      if (!vecs[i].en || vecs[i].wr)
        check("mem_write_data", i, bus_a.mem_write_data, vecs[i].wr ? WDATA : '0);
      check("icache_strobe", i, LW'(bus_a.enable_write_from_memory_to_icache), LW'(vecs[i].istb));
      check("dcache_strobe", i, LW'(bus_a.enable_write_from_memory_to_dcache), LW'(vecs[i].dstb));
      check("write_done",    i, LW'(bus_a.completed_write_to_memory), LW'(vecs[i].wdone));
      check("icache_data",   i, bus_a.to_icache_data, vecs[i].icd);
      check("dcache_data",   i, bus_a.to_dcache_data, vecs[i].dcd);
    end

    // MEM_LATENCY=1: back-to-back I-cache grants at edges 0 and 3
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("lat1_reset_busy", 0, LW'(bus_b.busy), '0);
    check("lat1_reset_data", 0, bus_b.to_icache_data, '0);
    bus_b.icache_request = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      check("lat1_busy",       c, LW'(bus_b.busy),       LW'(busy_b[c-1]));
      check("lat1_mem_enable", c, LW'(bus_b.mem_enable), LW'(en_b[c-1]));
      check("lat1_strobe",     c, LW'(bus_b.enable_write_from_memory_to_icache), LW'(stb_b[c-1]));
      if (c == 1 || c == 4) check("lat1_mem_address", c, LW'(bus_b.mem_address), LW'(32'h0000_00F0));
      if (c == 2) check("lat1_icache_data", c, bus_b.to_icache_data, pat(32'h0000_00F0));
      if (c == 5) bus_b.icache_request = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
